mem_arbiter: RTL and testbench

Single-port memory arbiter and pipeline stall controller for the five-stage MIPS core. Shares one unified instruction/data memory between instruction fetch (IF) and the memory stage (MEM, driven from the EX/MEM buffer outputs). Grants one access at a time and generates the stall signals that hold the pipeline buffers' `load` inputs low. MEM has priority over IF because it belongs to the older instruction. Also drops fetches cancelled by a taken jump.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/arb_timer.sv | 30 +++
 rtl/register.sv | 20 ++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  localparam int ARB_W       = 32;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IF  = 2'd1,
    GNT_MEM = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/arb_timer.sv
// Saturating wait counter; expired flags the LIMIT-th consecutive waiting cycle.
module arb_timer
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int            CW   = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt;

  // Count waiting cycles since the grant, holding at the last value.
  always_ff @(posedge clock) begin
    if (!reset || clear)
      cnt <= '0;
    else if (en && (cnt != LAST))
      cnt <= cnt + CW'(1);
  end

  // Already LIMIT-1 idle cycles behind us: this waiting cycle is the last allowed.
  assign expired = (cnt == LAST);

endmodule

// File: rtl/register.sv
// Generic load-enabled register with synchronous active-low reset.
module register #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d when load is asserted, clear on reset.
  always_ff @(posedge clock) begin
    if (!reset)
      q <= '0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter and stall controller: MEM stage over IF, one access at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH   = ARB_W,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  input  logic             ex_req,
  input  logic             ex_we,
  input  logic [WIDTH-1:0] ex_addr,
  input  logic [WIDTH-1:0] ex_wdata,
  input  logic             flush,
  output logic             mem_valid,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             if_done,
  output logic [WIDTH-1:0] if_data,
  output logic             ex_done,
  output logic [WIDTH-1:0] ex_data,
  output logic             stall_if,
  output logic             stall_pipe,
  output logic             bus_err
);

  arb_state_t       state, next_state;
  logic             resp_mem;   // the access in flight / just finished belongs to MEM
  logic             drop;       // fetch cancelled by a taken jump while on the bus
  logic [WIDTH-1:0] lat_addr;
  logic [WIDTH-1:0] lat_wdata;
  logic             lat_we;

  logic             granted;
  logic             expired;
  logic             finish;
  logic             timeout_hit;
  logic             if_load;
  logic             ex_load;
  logic [WIDTH-1:0] cap_data;

  assign granted     = (state == GNT_IF) || (state == GNT_MEM);
  // A ready in the timeout cycle wins, so it always completes normally.
  assign finish      = granted && (mem_ready || expired);
  assign timeout_hit = granted && expired && !mem_ready;
  assign cap_data    = mem_ready ? mem_rdata : '0;
  // A flush arriving in the completion cycle must also keep if_data untouched.
  assign if_load     = (state == GNT_IF) && finish && !drop && !flush;
  assign ex_load     = (state == GNT_MEM) && finish;

  arb_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (state == IDLE),
    .en      (granted && !mem_ready),
    .expired (expired)
  );

  register #(.WIDTH(WIDTH)) u_if_data (
    .clock (clock),
    .reset (reset),
    .load  (if_load),
    .d     (cap_data),
    .q     (if_data)
  );

  register #(.WIDTH(WIDTH)) u_ex_data (
    .clock (clock),
    .reset (reset),
    .load  (ex_load),
    .d     (cap_data),
    .q     (ex_data)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    next_state = state;
    mem_valid  = 1'b0;
    mem_we     = 1'b0;
    if_done    = 1'b0;
    ex_done    = 1'b0;
    case (state)
      IDLE: begin
        if (ex_req)
          next_state = GNT_MEM;
        else if (if_req && !flush)
          next_state = GNT_IF;
      end
      GNT_IF, GNT_MEM: begin
        mem_valid = 1'b1;
        mem_we    = lat_we;
        if (finish)
          next_state = RESP;
      end
      RESP: begin
        ex_done    = resp_mem;
        if_done    = !resp_mem && !drop;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Grant-time field latch, drop flag and sticky bus error.
  always_ff @(posedge clock) begin
    if (!reset) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      resp_mem  <= 1'b0;
      drop      <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      if ((state == IDLE) && (next_state != IDLE)) begin
        lat_addr  <= ex_req ? ex_addr : if_addr;
        lat_wdata <= ex_req ? ex_wdata : '0;
        lat_we    <= ex_req && ex_we;
        resp_mem  <= ex_req;
      end
      if ((state == GNT_IF) && flush)
        drop <= 1'b1;
      else if (state == RESP)
        drop <= 1'b0;
      if (timeout_hit)
        bus_err <= 1'b1;
    end
  end

  assign mem_addr   = lat_addr;
  assign mem_wdata  = lat_wdata;
  assign stall_pipe = ex_req && !ex_done;
  assign stall_if   = stall_pipe || (if_req && !if_done);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions plus corner sequences.
module tb_mem_arbiter;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          if_req;
  logic [W-1:0]  if_addr;
  logic          ex_req;
  logic          ex_we;
  logic [W-1:0]  ex_addr;
  logic [W-1:0]  ex_wdata;
  logic          flush;
  logic          mem_valid;
  logic          mem_we;
  logic [W-1:0]  mem_addr;
  logic [W-1:0]  mem_wdata;
  logic          mem_ready;
  logic [W-1:0]  mem_rdata;
  logic          if_done;
  logic [W-1:0]  if_data;
  logic          ex_done;
  logic [W-1:0]  ex_data;
  logic          stall_if;
  logic          stall_pipe;
  logic          bus_err;

  int n_total = 0;
  int n_pass  = 0;

  mem_arbiter #(.WIDTH(W), .TIMEOUT(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .ex_req     (ex_req),
    .ex_we      (ex_we),
    .ex_addr    (ex_addr),
    .ex_wdata   (ex_wdata),
    .flush      (flush),
    .mem_valid  (mem_valid),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .if_done    (if_done),
    .if_data    (if_data),
    .ex_done    (ex_done),
    .ex_data    (ex_data),
    .stall_if   (stall_if),
    .stall_pipe (stall_pipe),
    .bus_err    (bus_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_ex;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;   // granted cycles before mem_ready
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Advance to 2 time units past the next rising edge.
  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    if (v.is_ex) begin
      ex_req = 1'b1; ex_we = v.we; ex_addr = v.addr; ex_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    tick;
    for (int k = 0; k <= v.delay; k++) begin
      mem_ready = (k == v.delay);
      mem_rdata = (k == v.delay) ? v.rdata : 32'hFFFF_FFFF;
      #1;
      chk($sformatf("v%0d_valid", idx), {31'd0, mem_valid}, 32'd1);
      chk($sformatf("v%0d_addr", idx), mem_addr, v.addr);
      chk($sformatf("v%0d_we", idx), {31'd0, mem_we}, {31'd0, v.we});
      if (v.we)
        chk($sformatf("v%0d_wdata", idx), mem_wdata, v.wdata);
      chk($sformatf("v%0d_stall_if", idx), {31'd0, stall_if}, 32'd1);
      tick;
    end
    mem_ready = 1'b0;
    #1;
    chk($sformatf("v%0d_resp_valid", idx), {31'd0, mem_valid}, 32'd0);
    if (v.is_ex) begin
      chk($sformatf("v%0d_ex_done", idx), {31'd0, ex_done}, 32'd1);
      chk($sformatf("v%0d_ex_data", idx), ex_data, v.rdata);
      chk($sformatf("v%0d_if_done", idx), {31'd0, if_done}, 32'd0);
      chk($sformatf("v%0d_stall_pipe", idx), {31'd0, stall_pipe}, 32'd0);
    end else begin
      chk($sformatf("v%0d_if_done", idx), {31'd0, if_done}, 32'd1);
      chk($sformatf("v%0d_if_data", idx), if_data, v.rdata);
      chk($sformatf("v%0d_ex_done", idx), {31'd0, ex_done}, 32'd0);
      chk($sformatf("v%0d_stall_if", idx), {31'd0, stall_if}, 32'd0);
    end
    if_req = 1'b0; ex_req = 1'b0; ex_we = 1'b0;
    tick;
    #1;
    chk($sformatf("v%0d_idle_done", idx), {30'd0, if_done, ex_done}, 32'd0);
    chk($sformatf("v%0d_idle_stall", idx), {31'd0, stall_if}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic [31:0] old_if;

    vecs[0] = '{is_ex: 1'b0, we: 1'b0, addr: 32'h0040_0000, wdata: 32'h0,
                delay: 1, rdata: 32'h2008_0005};
    vecs[1] = '{is_ex: 1'b1, we: 1'b0, addr: 32'h1000_0000, wdata: 32'h0,
                delay: 0, rdata: 32'h1234_5678};
    vecs[2] = '{is_ex: 1'b1, we: 1'b1, addr: 32'h1000_0004, wdata: 32'hCAFE_F00D,
                delay: 2, rdata: 32'hAAAA_5555};
    vecs[3] = '{is_ex: 1'b0, we: 1'b0, addr: 32'h0040_0004, wdata: 32'h0,
                delay: 3, rdata: 32'h8C09_0000};

    reset = 1'b0; if_req = 1'b0; if_addr = '0; ex_req = 1'b0; ex_we = 1'b0;
    ex_addr = '0; ex_wdata = '0; flush = 1'b0; mem_ready = 1'b0; mem_rdata = '0;

    // Reset state
    tick; tick;
    chk("rst_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_flags", {27'd0, mem_we, if_done, ex_done, stall_pipe, bus_err}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_ex_data", ex_data, 32'd0);
    reset = 1'b1;
    tick;

    // Table of isolated transactions
    for (int i = 0; i < 4; i++)
      run_vec(i, vecs[i]);

    // Contention: store wins, fetch follows after RESP->IDLE
    if_req = 1'b1; if_addr = 32'h0040_0008;
    ex_req = 1'b1; ex_we = 1'b1; ex_addr = 32'h1000_0010; ex_wdata = 32'hDEAD_BEEF;
    #1;
    chk("con_stall_pipe_idle", {31'd0, stall_pipe}, 32'd1);
    tick;
    #1;
    chk("con_valid", {31'd0, mem_valid}, 32'd1);
    chk("con_we", {31'd0, mem_we}, 32'd1);
    chk("con_addr", mem_addr, 32'h1000_0010);
    chk("con_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("con_stall_pipe", {31'd0, stall_pipe}, 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'h0;
    tick;
    mem_ready = 1'b0;
    #1;
    chk("con_ex_done", {31'd0, ex_done}, 32'd1);
    chk("con_if_done", {31'd0, if_done}, 32'd0);
    chk("con_stall_pipe_done", {31'd0, stall_pipe}, 32'd0);
    chk("con_stall_if_pend", {31'd0, stall_if}, 32'd1);
    ex_req = 1'b0; ex_we = 1'b0;
    tick;
    #1;
    chk("con_idle_valid", {31'd0, mem_valid}, 32'd0);
    tick;
    #1;
    chk("con_if_valid", {31'd0, mem_valid}, 32'd1);
    chk("con_if_we", {31'd0, mem_we}, 32'd0);
    chk("con_if_addr", mem_addr, 32'h0040_0008);
    mem_ready = 1'b1; mem_rdata = 32'h0000_0042;
    tick;
    mem_ready = 1'b0;
    #1;
    chk("con_if_done", {31'd0, if_done}, 32'd1);
    chk("con_if_data", if_data, 32'h0000_0042);
    if_req = 1'b0;
    tick;

    // Flush during GNT_IF: access completes, result dropped
    old_if = if_data;
    if_req = 1'b1; if_addr = 32'h0040_000C;
    tick;
    flush = 1'b1;
    #1;
    chk("fl_valid1", {31'd0, mem_valid}, 32'd1);
    tick;
    flush = 1'b0;
    #1;
    chk("fl_valid2", {31'd0, mem_valid}, 32'd1);
    chk("fl_addr", mem_addr, 32'h0040_000C);
    mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick;
    mem_ready = 1'b0;
    #1;
    chk("fl_no_if_done", {31'd0, if_done}, 32'd0);
    chk("fl_if_data_held", if_data, old_if);
    chk("fl_resp_valid", {31'd0, mem_valid}, 32'd0);
    if_req = 1'b0;
    tick;
    #1;
    chk("fl_idle_done", {31'd0, if_done}, 32'd0);

    // Flush in IDLE: no grant
    if_req = 1'b1; if_addr = 32'h0040_0010; flush = 1'b1;
    tick;
    #1;
    chk("fli_no_grant", {31'd0, mem_valid}, 32'd0);
    if_req = 1'b0; flush = 1'b0;
    tick;

    // Timeout on a load with TIMEOUT=4
    ex_req = 1'b1; ex_we = 1'b0; ex_addr = 32'h1000_0020;
    tick;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("to_valid%0d", k), {31'd0, mem_valid}, 32'd1);
      chk($sformatf("to_err%0d", k), {31'd0, bus_err}, 32'd0);
      tick;
    end
    #1;
    chk("to_bus_err", {31'd0, bus_err}, 32'd1);
    chk("to_ex_done", {31'd0, ex_done}, 32'd1);
    chk("to_ex_data", ex_data, 32'd0);
    chk("to_resp_valid", {31'd0, mem_valid}, 32'd0);
    ex_req = 1'b0;
    tick;
    #1;
    chk("to_err_sticky", {31'd0, bus_err}, 32'd1);
    tick;

    // Reset in GNT_MEM
    ex_req = 1'b1; ex_we = 1'b1; ex_addr = 32'h1000_0030; ex_wdata = 32'h5555_AAAA;
    tick;
    #1;
    chk("rm_valid", {31'd0, mem_valid}, 32'd1);
    reset = 1'b0;
    tick;
    reset = 1'b1; ex_req = 1'b0; ex_we = 1'b0;
    #1;
    chk("rm_valid_off", {31'd0, mem_valid}, 32'd0);
    chk("rm_flags", {28'd0, mem_we, if_done, ex_done, bus_err}, 32'd0);
    chk("rm_addr", mem_addr, 32'd0);
    chk("rm_wdata", mem_wdata, 32'd0);
    chk("rm_if_data", if_data, 32'd0);
    chk("rm_ex_data", ex_data, 32'd0);
    tick;
    #1;
    chk("rm_no_done", {30'd0, if_done, ex_done}, 32'd0);
    chk("rm_still_idle", {31'd0, mem_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
